antidroop_seq_ctrl: RTL
=======================

// Module: antidroop_seq_ctrl
// PURPOSE
//  Sequencer/config controller for one anti-droop IIR channel (16-bit din, 7-bit signed tapWeight, accClr_en, oflowDetect).
//  Frames each beam pulse into a fixed sample window. Commits tap-weight/clear-enable writes only between pulses.
//  Latches and counts IIR overflow per pulse. Sits between the register/control interface and the IIR datapath.
// PARAMETERS
//  WIN_LEN      1024  pulse window length in clk cycles (>=2)
//  CNT_W        11    window counter width, must hold WIN_LEN
//  OCNT_W       8     overflow-pulse counter width (saturating)
// PORTS
//  clk           in   1       sample clock, shared with IIR
//  rst_n         in   1       async active-low reset
//  trig          in   1       async pulse trigger
//  wr_en         in   1       1-cycle config write strobe
//  wr_weight     in   7s      requested tap weight
//  wr_clr_en     in   1       requested accumulator-clear enable
//  wr_ack        out  1       1-cycle pulse when write committed to outputs
//  tap_weight    out  7s      committed weight -> IIR tapWeight
//  acc_clr_en    out  1       committed clear enable -> IIR accClr_en
//  oflow_in      in   1       IIR oflowDetect
//  oflow_clr     in   1       clears oflow_sticky and oflow_count
//  oflow_sticky  out  1       overflow seen since last clear
//  oflow_count   out  OCNT_W  pulses that saw overflow, saturating
//  pulse_active  out  1       high while window open
//  backoff_evt   out  1       1-cycle pulse on auto back-off (tied 0 without macro)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shadow empty, sync flops 0. Applies mid-pulse too: window aborted, no ack.
//  Trig sync: trig -> s1 -> s2 -> s3. edge = s2 & ~s3.
//    pulse_active rises at the 3rd rising clk edge after trig rises.
//  FSM IDLE -> ACTIVE on edge; counter loads 0.
//  ACTIVE: counter increments each cycle. At count==WIN_LEN-1 -> UPDATE. pulse_active high for exactly WIN_LEN cycles.
//    Further edges are ignored (no re-arm, no counter reset).
//  UPDATE (1 cycle) -> IDLE. An edge in UPDATE is ignored. The earliest next window starts from IDLE.
//  Writes: wr_en loads shadow {weight, clr_en} and sets pending; a later write before commit overwrites it (last wins, one ack).
//    Commit in IDLE: next cycle. Commit while ACTIVE: held until UPDATE.
//    Commit cycle updates tap_weight/acc_clr_en, asserts wr_ack for that cycle and clears pending.
//    wr_en in the same cycle as a commit: the new value becomes pending for the next commit opportunity, not lost.
//    IDLE commit and edge in the same cycle: commit wins; the window still opens.
//  Overflow: oflow_in is sampled only in ACTIVE. Any high sample sets the pulse flag and oflow_sticky.
//    In UPDATE, if the pulse flag is set: oflow_count += 1 (saturate at all-ones), then clear the flag.
//    oflow_clr and a set/increment in the same cycle: set/increment wins (sticky=1, count=1 if increment).
//  No arithmetic wrap anywhere: counters saturate or are bounded by the FSM.
// CONFIGURATION
//  `ANTIDROOP_AUTO_BACKOFF_EN defined:
//    In UPDATE with the pulse flag set and no pending write, tap_weight moves one LSB toward 0 (0 stays 0).
//    backoff_evt pulses that cycle. A pending write takes priority over back-off.
//  Undefined: no back-off logic; backoff_evt tied 0; tap_weight changes only on commit.
// STRUCTURE
//  Package antidroop_ctrl_pkg: state enum {IDLE, ACTIVE, UPDATE}, TAPW_W=7, default WIN_LEN.
//  Sub-module antidroop_trig_sync: 3-flop sync plus rising-edge detect, async reset. Reused by other IIR controllers.
//  Rest is flat: FSM, window counter, shadow/commit, overflow latch.
// TESTING
//  1 Reset then trig high at t0 -> pulse_active 1 at 3rd clk edge, high exactly WIN_LEN cycles, then 1 UPDATE cycle.
//  2 IDLE wr_en weight=-5 clr=1 -> next cycle tap_weight=-5, acc_clr_en=1, wr_ack one cycle.
//  3 Writes 10 then 20 during ACTIVE -> no ack until UPDATE; tap_weight=20, single wr_ack.
//  4 oflow_in high 1 cycle in each of 300 pulses (OCNT_W=8) -> sticky=1, count saturates at 255;
//    oflow_clr concurrent with UPDATE increment -> count=1.
//  5 Second trig mid-window and rst_n low mid-window -> window length unchanged; reset clears all outputs at once, no ack.
//  6 AUTO_BACKOFF_EN, weight=3, overflow in pulse -> UPDATE: weight 2, backoff_evt 1 cycle; weight=0 stays 0;
//    pending write beats back-off.

Source files
------------

// File: rtl/antidroop_ctrl_pkg.sv
// Shared types and constants for the anti-droop IIR channel controllers.
package antidroop_ctrl_pkg;

  localparam int unsigned TAPW_W      = 7;
  localparam int unsigned DEF_WIN_LEN = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    UPDATE = 2'd2
  } ctrl_state_e;

  typedef logic signed [TAPW_W-1:0] tapw_t;

  typedef struct packed {
    tapw_t weight;
    logic  clr_en;
  } shadow_t;

  // One LSB toward zero; zero is a fixed point.
  function automatic tapw_t step_toward_zero(input tapw_t w);
    tapw_t r;
    r = w;
    if (w[TAPW_W-1]) begin
      r = w + tapw_t'(1);
    end else if (w != '0) begin
      r = w - tapw_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/antidroop_trig_sync.sv
// Three-flop synchronizer for an asynchronous trigger with rising-edge detect.
module antidroop_trig_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= trig_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/antidroop_seq_ctrl.sv
// Pulse-window sequencer, between-pulse config commit and overflow latch for one IIR channel.
// Optional: define ANTIDROOP_AUTO_BACKOFF_EN for automatic tap-weight back-off on overflow.
module antidroop_seq_ctrl
  import antidroop_ctrl_pkg::*;
#(
  parameter int unsigned WIN_LEN = DEF_WIN_LEN,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned OCNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trig,
  input  logic                     wr_en,
  input  logic signed [TAPW_W-1:0] wr_weight,
  input  logic                     wr_clr_en,
  output logic                     wr_ack,
  output logic signed [TAPW_W-1:0] tap_weight,
  output logic                     acc_clr_en,
  input  logic                     oflow_in,
  input  logic                     oflow_clr,
  output logic                     oflow_sticky,
  output logic [OCNT_W-1:0]        oflow_count,
  output logic                     pulse_active,
  output logic                     backoff_evt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

  logic trig_rise;

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  shadow_t           shadow_q, shadow_d;
  tapw_t             tapw_q, tapw_d;
  logic              clren_q, clren_d;
  logic              ack_q, ack_d;
  logic              flag_q, flag_d;
  logic              sticky_q, sticky_d;
  logic [OCNT_W-1:0] ocnt_q, ocnt_d;
  logic              pa_q, pa_d;
  logic              bo_q, bo_d;

  logic commit;
  logic ovf_set;
  logic ovf_inc;

  antidroop_trig_sync u_trig_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .trig_i (trig),
    .rise_o (trig_rise)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    tapw_d   = tapw_q;
    clren_d  = clren_q;
    flag_d   = flag_q;
    sticky_d = sticky_q;
    ocnt_d   = ocnt_q;

    unique case (state_q)
      IDLE: begin
        if (trig_rise) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pa_d = (state_d == ACTIVE);

    // Commit uses the shadow as it stood before this cycle's write, so a
    // simultaneous write stays pending for the next opportunity.
    commit = pend_q && (state_q != ACTIVE);
    ack_d  = commit;
    if (commit) begin
      tapw_d  = shadow_q.weight;
      clren_d = shadow_q.clr_en;
      pend_d  = 1'b0;
    end
    if (wr_en) begin
      shadow_d = '{weight: wr_weight, clr_en: wr_clr_en};
      pend_d   = 1'b1;
    end

    ovf_set = (state_q == ACTIVE) && oflow_in;
    ovf_inc = (state_q == UPDATE) && flag_q;

`ifdef ANTIDROOP_AUTO_BACKOFF_EN
    bo_d = ovf_inc && !pend_q;
    if (bo_d) begin
      tapw_d = step_toward_zero(tapw_q);
    end
`else
    bo_d = 1'b0;
`endif

    if (ovf_set) begin
      flag_d = 1'b1;
    end else if (ovf_inc) begin
      flag_d = 1'b0;
    end

    // Set/increment outrank a concurrent clear.
    if (ovf_inc) begin
      if (oflow_clr) begin
        ocnt_d = OCNT_W'(1);
      end else if (ocnt_q != '1) begin
        ocnt_d = ocnt_q + 1'b1;
      end
    end else if (oflow_clr) begin
      ocnt_d = '0;
    end

    if (ovf_set || ovf_inc) begin
      sticky_d = 1'b1;
    end else if (oflow_clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      tapw_q   <= '0;
      clren_q  <= 1'b0;
      ack_q    <= 1'b0;
      flag_q   <= 1'b0;
      sticky_q <= 1'b0;
      ocnt_q   <= '0;
      pa_q     <= 1'b0;
      bo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      tapw_q   <= tapw_d;
      clren_q  <= clren_d;
      ack_q    <= ack_d;
      flag_q   <= flag_d;
      sticky_q <= sticky_d;
      ocnt_q   <= ocnt_d;
      pa_q     <= pa_d;
      bo_q     <= bo_d;
    end
  end

  assign wr_ack       = ack_q;
  assign tap_weight   = tapw_q;
  assign acc_clr_en   = clren_q;
  assign oflow_sticky = sticky_q;
  assign oflow_count  = ocnt_q;
  assign pulse_active = pa_q;
  assign backoff_evt  = bo_q;

endmodule
